serial_subtractor: RTL and testbench

- Bit-serial, LSB-first multi-bit subtractor computing A - B - Bin.
- Built from one full-subtractor cell and a borrow flip-flop. This is the inverse arithmetic of the combinational adder cells in the library.
- Used where area matters more than latency; results reach the datapath through a start/done handshake.
- Serves as the sequential counterpart for later arithmetic blocks, such as the restoring divider.

---
 rtl/serial_subtractor_if.sv | 26 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave returns status and results.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  ready, busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output ready, busy, done, diff, bout, ovf
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH RUN cycles.
// One full-subtractor cell plus a borrow flop; results appear only on entry to DONE.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor_if.slave   bus
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;

   logic             d_c;
   logic             br_next_c;
   logic [WIDTH-1:0] res_next_c;

   // Full-subtractor cell on the current LSBs; result bit enters from the MSB side
   always_comb begin
      d_c        = sa[0] ^ sb[0] ^ br;
      br_next_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
      res_next_c = (res >> 1) | (WIDTH'(d_c) << (WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sa      <= '0;
         sb      <= '0;
         res     <= '0;
         br      <= 1'b0;
         cnt     <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sa      <= bus.a;
                  sb      <= bus.b;
                  br      <= bus.bin;
                  res     <= '0;
                  cnt     <= '0;
                  state   <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next_c;
               res <= res_next_c;
               // Last bit: borrow into vs. out of the MSB gives signed overflow
               if (cnt == LAST) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  diff_q <= res_next_c;
                  bout_q <= br_next_c;
                  ovf_q  <= br ^ br_next_c;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.diff  = diff_q;
   assign bus.bout  = bout_q;
   assign bus.ovf   = ovf_q;

   // Handshake status flags are one-hot and done lasts exactly one cycle
   a_onehot_status: assert property (@(posedge clk) disable iff (rst)
      $onehot({ready_q, busy_q, done_q}));
   a_done_pulse: assert property (@(posedge clk) disable iff (rst)
      done_q |=> (!done_q && ready_q));

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: table of 8-bit vectors plus
// hand-written sequences for restart-ignore, async abort and WIDTH=1.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Issue one 8-bit operation and observe it until ready returns
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          output int lat, output int busy_n, output int done_n, output int excl_n);
      @(negedge clk);
      bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      lat = 0; busy_n = 0; done_n = 0; excl_n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            done_n++;
            if (lat == 0) lat = i;
         end
         if (int'(bus8.ready) + int'(bus8.busy) + int'(bus8.done) != 1) excl_n++;
         if (bus8.ready && lat != 0) break;
      end
   endtask

   initial begin
      int lat, busy_n, done_n, excl_n;
      logic [1:0] r;
      logic [2:0] cv;
      bit got;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
      vecs[8] = '{8'h7F, 8'h00, 1'b1, 8'h7E, 1'b0, 1'b0};

      rst = 1'b1;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ready",   32'(bus8.ready), 32'd1);
      chk("reset busy",    32'(bus8.busy),  32'd0);
      chk("reset done",    32'(bus8.done),  32'd0);
      chk("reset diff",    32'(bus8.diff),  32'd0);
      chk("reset bout",    32'(bus8.bout),  32'd0);
      chk("reset ovf",     32'(bus8.ovf),   32'd0);
      chk("reset w1 ready", 32'(bus1.ready), 32'd1);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_op8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, busy_n, done_n, excl_n);
         chk($sformatf("v%0d diff", i),    32'(bus8.diff), 32'(vecs[i].diff));
         chk($sformatf("v%0d bout", i),    32'(bus8.bout), 32'(vecs[i].bout));
         chk($sformatf("v%0d ovf", i),     32'(bus8.ovf),  32'(vecs[i].ovf));
         chk($sformatf("v%0d latency", i), 32'(lat),       32'd9);
         chk($sformatf("v%0d busy cycles", i), 32'(busy_n), 32'd8);
         chk($sformatf("v%0d done pulses", i), 32'(done_n), 32'd1);
         chk($sformatf("v%0d status onehot", i), 32'(excl_n), 32'd0);
      end

      // Second start during RUN is ignored; operand changes mid-run have no effect
      @(negedge clk);
      bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      done_n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 3) begin
            bus8.start = 1'b1; bus8.a = 8'hFF;
         end
         if (i == 4) begin
            bus8.start = 1'b0; bus8.a = 8'h33; bus8.b = 8'h77; bus8.bin = 1'b1;
         end
         if (bus8.done) done_n++;
         if (bus8.ready && done_n > 0) break;
      end
      chk("ignore diff",  32'(bus8.diff), 32'h0F);
      chk("ignore bout",  32'(bus8.bout), 32'd0);
      chk("ignore dones", 32'(done_n),    32'd1);
      repeat (3) begin
         @(negedge clk);
         if (bus8.done) done_n++;
      end
      chk("ignore no late done", 32'(done_n), 32'd1);

      // Asynchronous abort in the 4th RUN cycle
      @(negedge clk);
      bus8.a = 8'h5A; bus8.b = 8'h11; bus8.bin = 1'b0; bus8.start = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-abort busy", 32'(bus8.busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort ready", 32'(bus8.ready), 32'd1);
      chk("abort busy",  32'(bus8.busy),  32'd0);
      chk("abort diff",  32'(bus8.diff),  32'd0);
      chk("abort bout",  32'(bus8.bout),  32'd0);
      chk("abort ovf",   32'(bus8.ovf),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_n = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus8.done) done_n++;
      end
      chk("abort no done", 32'(done_n), 32'd0);
      run_op8(8'h0A, 8'h0A, 1'b0, lat, busy_n, done_n, excl_n);
      chk("post-abort diff",    32'(bus8.diff), 32'd0);
      chk("post-abort bout",    32'(bus8.bout), 32'd0);
      chk("post-abort ovf",     32'(bus8.ovf),  32'd0);
      chk("post-abort latency", 32'(lat),       32'd9);

      // WIDTH=1: start held high, a new operand set presented at each IDLE cycle
      bus1.start = 1'b1;
      for (int c = 0; c < 8; c++) begin
         cv = 3'(c);
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            if (bus1.ready) got = 1'b1;
            else @(negedge clk);
         end
         bus1.a = cv[2]; bus1.b = cv[1]; bus1.bin = cv[0];
         r = 2'(cv[2]) - 2'(cv[1]) - 2'(cv[0]);
         got = 1'b0;
         lat = 0;
         for (int t = 1; t <= 10 && !got; t++) begin
            @(negedge clk);
            if (bus1.done) begin
               got = 1'b1;
               lat = t;
            end
         end
         chk($sformatf("w1 c%0d latency", c), 32'(lat), 32'd2);
         chk($sformatf("w1 c%0d diff", c), 32'(bus1.diff), 32'(r[0]));
         chk($sformatf("w1 c%0d bout", c), 32'(bus1.bout), 32'(r[1]));
         chk($sformatf("w1 c%0d ovf", c),  32'(bus1.ovf),  32'(cv[0] ^ r[1]));
         @(negedge clk);
      end
      bus1.start = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
